soc_req_arbiter: RTL and testbench

SOC_REQ_ARBITER -- requirements
Module: soc_req_arbiter

---
 rtl/soc_req_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_soc_req_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_req_arbiter.sv
`default_nettype none
// ============================================================================
// soc_req_arbiter -- two-master round-robin arbiter with address decode,
// a single outstanding transaction and a slave-response watchdog.  Rev 1.0
// ============================================================================
module soc_req_arbiter #(
  parameter logic [63:0] DramLength    = 64'h4000_0000,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       mst_valid_i,
  output logic [1:0]       mst_ready_o,
  input  logic [1:0][63:0] mst_addr_i,
  input  logic [1:0]       mst_we_i,
  input  logic [1:0][63:0] mst_wdata_i,
  input  logic [1:0][3:0]  mst_id_i,
  output logic [1:0]       mst_rvalid_o,
  input  logic [1:0]       mst_rready_i,
  output logic [63:0]      mst_rdata_o,
  output logic             mst_err_o,
  output logic [3:0]       mst_rid_o,
  output logic             slv_valid_o,
  input  logic             slv_ready_i,
  output logic [63:0]      slv_addr_o,
  output logic             slv_we_o,
  output logic [63:0]      slv_wdata_o,
  output logic [3:0]       slv_sel_o,
  output logic [4:0]       slv_id_o,
  input  logic             slv_rvalid_i,
  input  logic [63:0]      slv_rdata_i,
  input  logic             slv_err_i
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FWD  = 3'd1,
    ST_WAIT = 3'd2,
    ST_ERR  = 3'd3,
    ST_RSP  = 3'd4
  } state_e;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TimeoutCycles - 1);

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        idx_q, idx_d;
  logic [3:0]  id_q, id_d;
  logic [63:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [63:0] wdata_q, wdata_d;
  logic [3:0]  sel_q, sel_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [15:0] wdog_q, wdog_d;
  logic        pend_q, pend_d;
  logic        slv_valid_q, slv_valid_d;
  logic [1:0]  rvalid_q, rvalid_d;

  logic        win_idx;
  logic        grant;
  logic [63:0] win_addr;
  logic        dec_hit;
  logic [3:0]  dec_sel;

  // Region end is computed in 65 bits so a region touching 2^64 cannot wrap.
  function automatic logic in_range(input logic [63:0] a, input logic [63:0] base,
                                    input logic [63:0] len);
    logic [64:0] a_x;
    logic [64:0] base_x;
    a_x    = {1'b0, a};
    base_x = {1'b0, base};
    return (a_x >= base_x) && (a_x < (base_x + {1'b0, len}));
  endfunction

  always_comb begin
    win_idx = 1'b0;
    if (mst_valid_i == 2'b11) win_idx = ~last_grant_q;
    else if (mst_valid_i[1])  win_idx = 1'b1;
  end

  assign grant       = (state_q == ST_IDLE) && (|mst_valid_i) && !rst_i;
  assign mst_ready_o = grant ? {win_idx, ~win_idx} : 2'b00;
  assign win_addr    = mst_addr_i[win_idx];

  always_comb begin
    dec_hit = 1'b1;
    dec_sel = 4'd0;
    if      (in_range(win_addr, 64'h0000_0000, 64'h0000_1000)) dec_sel = 4'd8;
    else if (in_range(win_addr, 64'h0001_0000, 64'h0001_0000)) dec_sel = 4'd7;
    else if (in_range(win_addr, 64'h0200_0000, 64'h000C_0000)) dec_sel = 4'd6;
    else if (in_range(win_addr, 64'h0C00_0000, 64'h03FF_FFFF)) dec_sel = 4'd5;
    else if (in_range(win_addr, 64'h1000_0000, 64'h0000_1000)) dec_sel = 4'd4;
    else if (in_range(win_addr, 64'h2000_0000, 64'h0080_0000)) dec_sel = 4'd3;
    else if (in_range(win_addr, 64'h3000_0000, 64'h0001_0000)) dec_sel = 4'd2;
    else if (in_range(win_addr, 64'h4000_0000, 64'h0000_1000)) dec_sel = 4'd1;
    else if (in_range(win_addr, 64'h8000_0000, DramLength))    dec_sel = 4'd0;
    else dec_hit = 1'b0;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    idx_d        = idx_q;
    id_d         = id_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    sel_d        = sel_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    wdog_d       = wdog_q;
    pend_d       = pend_q;
    slv_valid_d  = slv_valid_q;
    rvalid_d     = rvalid_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          last_grant_d = win_idx;
          idx_d        = win_idx;
          id_d         = mst_id_i[win_idx];
          addr_d       = win_addr;
          we_d         = mst_we_i[win_idx];
          wdata_d      = mst_wdata_i[win_idx];
          sel_d        = dec_sel;
          wdog_d       = 16'd0;
          pend_d       = 1'b0;
          if (dec_hit) begin
            state_d     = ST_FWD;
            slv_valid_d = 1'b1;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_FWD: begin
        wdog_d = wdog_q + 16'd1;
        if (wdog_q == TIMEOUT_LAST) begin
          slv_valid_d = 1'b0;
          rdata_d     = 64'd0;
          err_d       = 1'b1;
          rvalid_d    = {idx_q, ~idx_q};
          state_d     = ST_RSP;
        end else if (slv_ready_i) begin
          slv_valid_d = 1'b0;
          state_d     = ST_WAIT;
          // A response coinciding with the accept is held for WAIT to deliver.
          if (slv_rvalid_i) begin
            pend_d  = 1'b1;
            rdata_d = slv_rdata_i;
            err_d   = slv_err_i;
          end
        end
      end
      ST_WAIT: begin
        wdog_d = wdog_q + 16'd1;
        if (pend_q || slv_rvalid_i) begin
          if (!pend_q) begin
            rdata_d = slv_rdata_i;
            err_d   = slv_err_i;
          end
          pend_d   = 1'b0;
          rvalid_d = {idx_q, ~idx_q};
          state_d  = ST_RSP;
        end else if (wdog_q == TIMEOUT_LAST) begin
          rdata_d  = 64'd0;
          err_d    = 1'b1;
          rvalid_d = {idx_q, ~idx_q};
          state_d  = ST_RSP;
        end
      end
      ST_ERR: begin
        rdata_d  = 64'd0;
        err_d    = 1'b1;
        rvalid_d = {idx_q, ~idx_q};
        state_d  = ST_RSP;
      end
      ST_RSP: begin
        if (|(rvalid_q & mst_rready_i)) begin
          rvalid_d = 2'b00;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      idx_q        <= 1'b0;
      id_q         <= 4'd0;
      addr_q       <= 64'd0;
      we_q         <= 1'b0;
      wdata_q      <= 64'd0;
      sel_q        <= 4'd0;
      rdata_q      <= 64'd0;
      err_q        <= 1'b0;
      wdog_q       <= 16'd0;
      pend_q       <= 1'b0;
      slv_valid_q  <= 1'b0;
      rvalid_q     <= 2'b00;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      idx_q        <= idx_d;
      id_q         <= id_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      sel_q        <= sel_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      wdog_q       <= wdog_d;
      pend_q       <= pend_d;
      slv_valid_q  <= slv_valid_d;
      rvalid_q     <= rvalid_d;
    end
  end

  assign slv_valid_o  = slv_valid_q;
  assign slv_addr_o   = addr_q;
  assign slv_we_o     = we_q;
  assign slv_wdata_o  = wdata_q;
  assign slv_sel_o    = sel_q;
  assign slv_id_o     = {idx_q, id_q};
  assign mst_rvalid_o = rvalid_q;
  assign mst_rdata_o  = rdata_q;
  assign mst_err_o    = err_q;
  assign mst_rid_o    = id_q;

endmodule
`default_nettype wire

// File: tb/tb_soc_req_arbiter.sv
`default_nettype none
// ============================================================================
// tb_soc_req_arbiter -- directed and randomized bench with a region-table
// reference model for soc_req_arbiter.  Rev 1.0
// ============================================================================
module tb_soc_req_arbiter;

  localparam int unsigned TO       = 8;
  localparam logic [63:0] DRAM_LEN = 64'h4000_0000;

  // Debug, ROM, CLINT, PLIC, UART, SPI, Ethernet, GPIO, DRAM
  localparam logic [63:0] R_BASE [9] = '{64'h0, 64'h1_0000, 64'h200_0000, 64'hC00_0000,
      64'h1000_0000, 64'h2000_0000, 64'h3000_0000, 64'h4000_0000, 64'h8000_0000};
  localparam logic [63:0] R_LEN [9] = '{64'h1000, 64'h1_0000, 64'hC_0000, 64'h3FF_FFFF,
      64'h1000, 64'h80_0000, 64'h1_0000, 64'h1000, DRAM_LEN};
  localparam logic [3:0] R_SEL [9] = '{4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
  localparam logic [63:0] R_MISS [3] = '{64'h5000_0000, 64'hC000_0000, 64'h0000_1000};

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic [1:0]       mst_valid_i = '0;
  logic [1:0]       mst_ready_o;
  logic [1:0][63:0] mst_addr_i = '0;
  logic [1:0]       mst_we_i = '0;
  logic [1:0][63:0] mst_wdata_i = '0;
  logic [1:0][3:0]  mst_id_i = '0;
  logic [1:0]       mst_rvalid_o;
  logic [1:0]       mst_rready_i = '0;
  logic [63:0]      mst_rdata_o;
  logic             mst_err_o;
  logic [3:0]       mst_rid_o;
  logic             slv_valid_o;
  logic             slv_ready_i = 1'b0;
  logic [63:0]      slv_addr_o;
  logic             slv_we_o;
  logic [63:0]      slv_wdata_o;
  logic [3:0]       slv_sel_o;
  logic [4:0]       slv_id_o;
  logic             slv_rvalid_i = 1'b0;
  logic [63:0]      slv_rdata_i = '0;
  logic             slv_err_i = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  logic model_last = 1'b1;

  soc_req_arbiter #(.DramLength(DRAM_LEN), .TimeoutCycles(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mst_valid_i(mst_valid_i), .mst_ready_o(mst_ready_o), .mst_addr_i(mst_addr_i),
    .mst_we_i(mst_we_i), .mst_wdata_i(mst_wdata_i), .mst_id_i(mst_id_i),
    .mst_rvalid_o(mst_rvalid_o), .mst_rready_i(mst_rready_i), .mst_rdata_o(mst_rdata_o),
    .mst_err_o(mst_err_o), .mst_rid_o(mst_rid_o),
    .slv_valid_o(slv_valid_o), .slv_ready_i(slv_ready_i), .slv_addr_o(slv_addr_o),
    .slv_we_o(slv_we_o), .slv_wdata_o(slv_wdata_o), .slv_sel_o(slv_sel_o),
    .slv_id_o(slv_id_o), .slv_rvalid_i(slv_rvalid_i), .slv_rdata_i(slv_rdata_i),
    .slv_err_i(slv_err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic void decode_ref(input logic [63:0] a, output logic hit,
                                     output logic [3:0] sel);
    hit = 1'b0;
    sel = 4'd0;
    for (int i = 0; i < 9; i++)
      if (a >= R_BASE[i] && (a - R_BASE[i]) < R_LEN[i]) begin
        hit = 1'b1;
        sel = R_SEL[i];
      end
  endfunction

  function automatic logic [63:0] rand_addr();
    int unsigned r;
    logic [31:0] span;
    r = $urandom_range(0, 11);
    if (r < 9) begin
      span = R_LEN[r][31:0] - 32'd1;
      return R_BASE[r] + {32'd0, 32'($urandom_range(0, span))};
    end
    return R_MISS[r - 9];
  endfunction

  task automatic set_mst(input int m, input logic [63:0] a, input logic we,
                         input logic [63:0] wd, input logic [3:0] id);
    mst_addr_i[m]  = a;
    mst_we_i[m]    = we;
    mst_wdata_i[m] = wd;
    mst_id_i[m]    = id;
  endtask

  // One complete transaction from an IDLE cycle; slave timing is given by rd/rv.
  task automatic run_txn(input logic [1:0] valids, input int rd, input int rv,
                         input logic respond, input logic [63:0] sdata, input logic serr,
                         input int rwait, input logic stray);
    logic w, hit, to, exp_err;
    logic [3:0] sel;
    logic [1:0] oh;
    logic [63:0] exp_data;
    int rsp_k;
    mst_valid_i = valids;
    #1;
    w  = (valids == 2'b11) ? ~model_last : valids[1];
    oh = w ? 2'b10 : 2'b01;
    check("grant", 64'(mst_ready_o), 64'(oh));
    decode_ref(mst_addr_i[w], hit, sel);
    to = hit && !respond;
    if (!hit)    rsp_k = 2;
    else if (to) rsp_k = TO + 1;
    else         rsp_k = 2 + rd + ((rv > 0) ? rv : 1);
    exp_data   = (hit && !to) ? sdata : 64'd0;
    exp_err    = (hit && !to) ? serr : 1'b1;
    model_last = w;
    for (int k = 1; k <= rsp_k; k++) begin
      tick();
      slv_ready_i  = hit && (k == 1 + rd);
      slv_rvalid_i = (hit && respond && (k == 1 + rd + rv)) || (stray && !hit && k == 1);
      slv_rdata_i  = stray && !hit ? 64'hDEAD_BEEF : sdata;
      slv_err_i    = stray && !hit ? 1'b0 : serr;
      #1;
      check("ready_busy", 64'(mst_ready_o), 64'd0);
      check("slv_valid", 64'(slv_valid_o), 64'(hit && (k <= 1 + rd)));
      if (hit && k <= 1 + rd) begin
        check("slv_addr", slv_addr_o, mst_addr_i[w]);
        check("slv_we", 64'(slv_we_o), 64'(mst_we_i[w]));
        check("slv_wdata", slv_wdata_o, mst_wdata_i[w]);
        check("slv_sel", 64'(slv_sel_o), 64'(sel));
        check("slv_id", 64'(slv_id_o), 64'({w, mst_id_i[w]}));
      end
      check("rvalid_time", 64'(mst_rvalid_o), (k == rsp_k) ? 64'(oh) : 64'd0);
    end
    slv_ready_i  = 1'b0;
    slv_rvalid_i = 1'b0;
    check("rdata", mst_rdata_o, exp_data);
    check("err", 64'(mst_err_o), 64'(exp_err));
    check("rid", 64'(mst_rid_o), 64'(mst_id_i[w]));
    for (int i = 0; i < rwait; i++) begin
      tick();
      mst_rready_i = ~oh;
      #1;
      check("rvalid_hold", 64'(mst_rvalid_o), 64'(oh));
    end
    tick();
    mst_rready_i = oh;
    #1;
    check("no_grant_in_rsp", 64'(mst_ready_o), 64'd0);
    tick();
    mst_rready_i = 2'b00;
    mst_valid_i  = 2'b00;
    #1;
    check("rvalid_clear", 64'(mst_rvalid_o), 64'd0);
  endtask

  initial begin
    mst_valid_i = 2'b11;
    repeat (2) @(posedge clk_i);
    #2;
    check("rst_ready", 64'(mst_ready_o), 64'd0);
    check("rst_slv_valid", 64'(slv_valid_o), 64'd0);
    check("rst_rvalid", 64'(mst_rvalid_o), 64'd0);
    check("rst_err", 64'(mst_err_o), 64'd0);
    check("rst_rdata", mst_rdata_o, 64'd0);
    check("rst_slv_addr", slv_addr_o, 64'd0);
    check("rst_slv_id", 64'(slv_id_o), 64'd0);
    @(negedge clk_i);
    rst_i       = 1'b0;
    mst_valid_i = 2'b00;
    tick();

    // UART read with immediate slave, then same-cycle accept+response
    set_mst(0, 64'h1000_0000, 1'b0, 64'd0, 4'h5);
    run_txn(2'b01, 0, 1, 1'b1, 64'hAB, 1'b0, 0, 1'b0);
    run_txn(2'b01, 0, 0, 1'b1, 64'h1234, 1'b1, 1, 1'b0);

    // Unmapped write from master 1, with a stray slave response during ERR
    set_mst(1, 64'h5000_0000, 1'b1, 64'hCAFE, 4'hA);
    run_txn(2'b10, 0, 0, 1'b1, 64'd0, 1'b0, 0, 1'b1);

    // Watchdog expiry, then a stray response while idle
    set_mst(0, 64'h8000_0100, 1'b0, 64'd0, 4'h3);
    run_txn(2'b01, 1, 0, 1'b0, 64'h77, 1'b0, 0, 1'b0);
    tick();
    slv_rvalid_i = 1'b1;
    slv_rdata_i  = 64'h0BAD;
    tick();
    slv_rvalid_i = 1'b0;
    #1;
    check("stray_rvalid", 64'(mst_rvalid_o), 64'd0);
    check("stray_rdata", mst_rdata_o, 64'd0);

    // Decode boundaries
    set_mst(0, 64'h8000_0000 + DRAM_LEN - 64'd1, 1'b0, 64'd0, 4'h1);
    run_txn(2'b01, 0, 1, 1'b1, 64'h11, 1'b0, 0, 1'b0);
    set_mst(0, 64'h8000_0000 + DRAM_LEN, 1'b0, 64'd0, 4'h2);
    run_txn(2'b01, 0, 1, 1'b1, 64'h22, 1'b0, 0, 1'b0);
    set_mst(1, 64'h1_0000, 1'b0, 64'd0, 4'h4);
    run_txn(2'b10, 0, 1, 1'b1, 64'h33, 1'b0, 0, 1'b0);
    set_mst(1, 64'h0FFF, 1'b1, 64'h99, 4'h6);
    run_txn(2'b10, 2, 2, 1'b1, 64'h44, 1'b0, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      for (int m = 0; m < 2; m++)
        set_mst(m, rand_addr(), 1'($urandom_range(0, 1)), {$urandom, $urandom},
                4'($urandom_range(0, 15)));
      run_txn(2'($urandom_range(1, 3)), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 2)), ($urandom_range(0, 7) != 0),
              {$urandom, $urandom}, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    // Reset while waiting for the slave response
    set_mst(0, 64'h8000_1000, 1'b0, 64'd0, 4'h1);
    set_mst(1, 64'h4000_0010, 1'b1, 64'h55, 4'h2);
    mst_valid_i = 2'b01;
    tick();
    mst_valid_i = 2'b00;
    tick();
    slv_ready_i = 1'b1;
    tick();
    slv_ready_i = 1'b0;
    #1;
    check("pre_rst_slv_valid", 64'(slv_valid_o), 64'd0);
    #2;
    rst_i       = 1'b1;
    mst_valid_i = 2'b11;
    #1;
    check("async_rst_ready", 64'(mst_ready_o), 64'd0);
    check("async_rst_slv_addr", slv_addr_o, 64'd0);
    check("async_rst_slv_id", 64'(slv_id_o), 64'd0);
    tick();
    slv_rvalid_i = 1'b1;
    tick();
    slv_rvalid_i = 1'b0;
    #2;
    rst_i      = 1'b0;
    model_last = 1'b1;
    check("post_rst_rvalid", 64'(mst_rvalid_o), 64'd0);
    for (int t = 0; t < 4; t++)
      run_txn(2'b11, 0, 1, 1'b1, 64'(t + 100), 1'b0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
